// File: rtl/sound_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sound_event_arbiter
//  Description : N-channel fixed-priority sound event arbiter for a tone
//                generator. Channel 0 has the highest priority. Each channel
//                has a fixed tone and duration. An optional silent gap
//                separates consecutive sounds.
//                Optional feature macro: SOUND_PENDING_EN. When defined,
//                requests that are not accepted are remembered and replayed
//                from idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sound_event_arbiter #(
  parameter int                     N_CH       = 4,
  parameter int                     TONE_W     = 4,
  parameter int                     DUR_W      = 24,
  parameter logic [N_CH*TONE_W-1:0] CH_TONES   = '0,
  parameter logic [N_CH*DUR_W-1:0]  CH_DURS    = {N_CH{DUR_W'(5000000)}},
  parameter int                     GAP_CYCLES = 0,
  localparam int                    CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   event_req,
  input  logic              mute,
  output logic              sound_en,
  output logic [TONE_W-1:0] tone,
  output logic [CH_W-1:0]   active_ch,
  output logic              busy
);

  localparam logic [DUR_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? DUR_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;
  logic                sound_en_q, sound_en_d;
  logic [TONE_W-1:0]   tone_q, tone_d;
  logic [CH_W-1:0]     active_ch_q, active_ch_d;
  logic                busy_q, busy_d;
  logic [N_CH-1:0]     w_arb_vec;
  logic [CH_W-1:0]     w_win;

  // Counter load value for a channel; a zero duration still plays one cycle.
  function automatic logic [DUR_W-1:0] dur_load(input logic [CH_W-1:0] c);
    logic [DUR_W-1:0] d;
    d = CH_DURS[int'(c)*DUR_W +: DUR_W];
    return (d == '0) ? '0 : d - DUR_W'(1);
  endfunction

  function automatic logic [TONE_W-1:0] tone_of(input logic [CH_W-1:0] c);
    return CH_TONES[int'(c)*TONE_W +: TONE_W];
  endfunction

`ifdef SOUND_PENDING_EN
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] w_accept;

  // Idle arbitration also sees remembered requests; play arbitration does not.
  assign w_arb_vec = (state_q == S_IDLE) ? (event_req | pending_q) : event_req;

  // One-hot of the channel that starts (or restarts) playing this cycle.
  always_comb begin
    w_accept = '0;
    if ((state_q == S_IDLE && (|w_arb_vec)) ||
        (state_q == S_PLAY && (|event_req) && (w_win <= ch_q))) begin
      w_accept = N_CH'(1) << w_win;
    end
  end

  // Unaccepted requests are remembered; a channel's bit clears when it starts.
  always_comb begin
    pending_d = (pending_q | (event_req & ~w_accept)) & ~w_accept;
  end

  // Pending request register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  assign w_arb_vec = event_req;
`endif

  // Lowest set index wins.
  always_comb begin
    w_win = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_arb_vec[k]) w_win = CH_W'(k);
    end
  end

  // Next-state logic and the values the output register will capture.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|w_arb_vec) begin
          state_d = S_PLAY;
          ch_d    = w_win;
          cnt_d   = dur_load(w_win);
        end
      end
      S_PLAY: begin
        if ((|event_req) && (w_win <= ch_q)) begin
          ch_d  = w_win;
          cnt_d = dur_load(w_win);
        end else if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DUR_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - DUR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    sound_en_d  = (state_d == S_PLAY) && !mute;
    tone_d      = sound_en_d ? tone_of(ch_d) : '0;
    active_ch_d = (state_d == S_PLAY) ? ch_d : '0;
    busy_d      = (state_d != S_IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      sound_en_q  <= 1'b0;
      tone_q      <= '0;
      active_ch_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      sound_en_q  <= sound_en_d;
      tone_q      <= tone_d;
      active_ch_q <= active_ch_d;
      busy_q      <= busy_d;
    end
  end

  assign sound_en  = sound_en_q;
  assign tone      = tone_q;
  assign active_ch = active_ch_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
